adc_frame_packer: RTL and testbench

Sits between the ADC controller's 16-bit sample output and the SDRAM FIFO write side. Packs the raw sample stream into fixed-length frames. Each frame is one sync word, one 16-bit sequence number, then FRAME_LEN samples, so host software can realign after drops. A small internal FIFO absorbs samples while header words are emitted, and a sticky flag reports samples lost to overflow.

---
 rtl/adc_frame_packer.sv | 126 ++++++++++++
 tb/tb_adc_frame_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
// Packs the ADC sample stream into frames of sync word, sequence number and FRAME_LEN samples.
// A small FIFO buffers samples while the header words go out; overrun latches any dropped sample.
//   state | meaning
//   IDLE  | no frame on the output, waiting for a buffered sample
//   SYNC  | presenting SYNC_WORD
//   SEQ   | presenting the frame sequence number
//   DATA  | presenting FIFO head until FRAME_LEN samples have been sent
module adc_frame_packer #(
  parameter int unsigned FRAME_LEN = 256,
  parameter logic [15:0] SYNC_WORD = 16'hA5A5,
  parameter int unsigned DEPTH     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        overrun,
  input  logic        overrun_clear,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    SEQ  = 2'd2,
    DATA = 2'd3
  } stateType;

  stateType    state;
  stateType    stateNext;
  logic [15:0] mem [DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic [15:0] inCnt;
  logic [15:0] outCnt;
  logic [15:0] seq;
  logic        fifoEmpty;
  logic        fifoFull;
  logic        accept;
  logic        doWrite;
  logic        doDrop;
  logic        xfer;
  logic        doPop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  // Once a frame has started, its remaining samples are taken regardless of enable.
  assign accept  = sample_valid && (enable || (inCnt != 16'd0));
  assign doWrite = accept && !fifoFull;
  assign doDrop  = accept && fifoFull;
  assign xfer    = dout_valid && dout_ready;
  assign doPop   = xfer && (state == DATA);

  always_comb begin
    stateNext  = state;
    dout       = 16'd0;
    dout_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty) stateNext = SYNC;
      end
      SYNC: begin
        dout       = SYNC_WORD;
        dout_valid = 1'b1;
        if (dout_ready) stateNext = SEQ;
      end
      SEQ: begin
        dout       = seq;
        dout_valid = 1'b1;
        if (dout_ready) stateNext = DATA;
      end
      DATA: begin
        dout       = mem[rdPtr[AW-1:0]];
        dout_valid = !fifoEmpty;
        if (!fifoEmpty && dout_ready && (outCnt == LAST_IDX)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      wrPtr   <= '0;
      rdPtr   <= '0;
      inCnt   <= 16'd0;
      outCnt  <= 16'd0;
      seq     <= 16'd0;
      overrun <= 1'b0;
    end else begin
      state <= stateNext;
      if (doWrite) begin
        wrPtr <= wrPtr + 1'b1;
        inCnt <= (inCnt == LAST_IDX) ? 16'd0 : inCnt + 16'd1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      if ((state == SEQ) && xfer) begin
        seq    <= seq + 16'd1;
        outCnt <= 16'd0;
      end else if (doPop) begin
        outCnt <= outCnt + 16'd1;
      end
      if (doDrop) overrun <= 1'b1;
      else if (overrun_clear) overrun <= 1'b0;
    end
  end

  // Sample storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr[AW-1:0]] <= sample_in;
  end

  assign frame_count = seq;
  assign busy        = (state != IDLE) || (inCnt != 16'd0) || !fifoEmpty;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer: a queue model predicts the output word stream,
// overrun and busy; a negedge monitor pops and compares on every output transfer.
module tb_adc_frame_packer;

  localparam int          FL = 4;
  localparam int          DP = 8;
  localparam logic [15:0] SW = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] sample_in = 16'd0;
  logic        sample_valid = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        overrun;
  logic        overrun_clear = 1'b0;
  logic [15:0] frame_count;
  logic        busy;

  always #5 clk = ~clk;

  adc_frame_packer #(.FRAME_LEN(FL), .SYNC_WORD(SW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .overrun(overrun), .overrun_clear(overrun_clear),
    .frame_count(frame_count), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model state: expected word stream with kind tags (0 data, 1 sync, 2 seq).
  logic [15:0] expW[$];
  int          expK[$];
  int          wrTotal = 0;
  int          popTotal = 0;
  int          popBase = 0;
  int          lastPop = 0;
  int          mPos = 0;
  logic [15:0] mSeq = 16'd0;
  bit          mOvr = 1'b0;
  logic [15:0] expFc = 16'd0;
  bit          preloadReq = 1'b0;
  logic [15:0] preloadVal = 16'd0;
  int          xferCyc[$];
  bit          holdPending = 1'b0;
  logic [15:0] holdWord = 16'd0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: frame position, FIFO occupancy and sticky overrun from the input rules.
  always @(posedge clk) begin
    int occ;
    bit acc;
    bit drop;
    drop = 1'b0;
    if (!rst) begin
      expW.delete();
      expK.delete();
      wrTotal = 0;
      popBase = popTotal;
      mPos    = 0;
      mSeq    = 16'd0;
      mOvr    = 1'b0;
    end else begin
      if (preloadReq) mSeq = preloadVal;
      occ = wrTotal - (popTotal - popBase) + lastPop;
      acc = sample_valid && (enable || (mPos != 0));
      if (acc) begin
        if (occ >= DP) begin
          drop = 1'b1;
        end else begin
          if (mPos == 0) begin
            expW.push_back(SW);   expK.push_back(1);
            expW.push_back(mSeq); expK.push_back(2);
            mSeq = mSeq + 16'd1;
          end
          expW.push_back(sample_in); expK.push_back(0);
          wrTotal++;
          mPos = (mPos + 1) % FL;
        end
      end
      if (drop) mOvr = 1'b1;
      else if (overrun_clear) mOvr = 1'b0;
    end
  end

  // Monitor: status checks every cycle, handshake stability, word compare on each transfer.
  always @(negedge clk) begin
    logic [15:0] w;
    int k;
    cyc++;
    if (!rst) begin
      expFc       = 16'd0;
      lastPop     = 0;
      holdPending = 1'b0;
    end else begin
      if (preloadReq) expFc = preloadVal;
      check("overrun", 16'(overrun), 16'(mOvr));
      check("frame_count", frame_count, expFc);
      check("busy", 16'(busy), 16'((expW.size() != 0) || (mPos != 0)));
      if (holdPending) begin
        check("hold_valid", 16'(dout_valid), 16'd1);
        check("hold_data", dout, holdWord);
      end
      lastPop     = 0;
      holdPending = dout_valid && !dout_ready;
      holdWord    = dout;
      if (dout_valid && dout_ready) begin
        xferCyc.push_back(cyc);
        if (expW.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h want no transfer (cycle %0d)", dout, cyc);
        end else begin
          w = expW.pop_front();
          k = expK.pop_front();
          check("dout", dout, w);
          if (k == 2) expFc = w + 16'd1;
          if (k == 0) begin
            popTotal++;
            lastPop = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendSample(input logic [15:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    sample_valid = 1'b0;
    dout_ready   = 1'b1;
    while ((busy || (expW.size() != 0)) && (n < budget)) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_dout", dout, 16'd0);
    check("rst_dout_valid", 16'(dout_valid), 16'd0);
    tick();

    // 1: spaced samples, single frame
    enable = 1'b1;
    dout_ready = 1'b1;
    xferCyc.delete();
    for (int i = 1; i <= 4; i++) begin
      sendSample(16'(i));
      repeat (2) tick();
    end
    waitIdle(50);
    check("t1_words", 16'(xferCyc.size()), 16'd6);

    // 2: back-to-back frames, one idle cycle between them
    xferCyc.delete();
    for (int i = 1; i <= 8; i++) sendSample(16'(i));
    waitIdle(50);
    check("t2_words", 16'(xferCyc.size()), 16'd12);
    if (xferCyc.size() == 12) check("t2_span", 16'(xferCyc[11] - xferCyc[0]), 16'd12);

    // 3: output stalled, FIFO fills, excess samples dropped
    dout_ready = 1'b0;
    xferCyc.delete();
    for (int i = 0; i < 12; i++) sendSample(16'($urandom));
    repeat (8) tick();
    check("t3_overrun_set", 16'(overrun), 16'd1);
    overrun_clear = 1'b1;
    sendSample(16'h7777);
    check("t3_clear_vs_drop", 16'(overrun), 16'd1);
    tick();
    check("t3_clear", 16'(overrun), 16'd0);
    overrun_clear = 1'b0;
    waitIdle(60);
    check("t3_words", 16'(xferCyc.size()), 16'd12);
    if (xferCyc.size() == 12) check("t3_span", 16'(xferCyc[11] - xferCyc[0]), 16'd12);

    // 4: enable drops mid-frame; later sample outside the window ignored
    xferCyc.delete();
    enable = 1'b1;
    sendSample(16'h1111);
    sendSample(16'h2222);
    enable = 1'b0;
    sendSample(16'h3333);
    sendSample(16'h4444);
    waitIdle(50);
    check("t4_words", 16'(xferCyc.size()), 16'd6);
    sendSample(16'h5555);
    repeat (3) tick();
    check("t4_ignored_valid", 16'(dout_valid), 16'd0);
    check("t4_ignored_busy", 16'(busy), 16'd0);
    check("t4_ignored_overrun", 16'(overrun), 16'd0);

    // 5: reset while in DATA with words still queued
    enable = 1'b1;
    dout_ready = 1'b0;
    xferCyc.delete();
    for (int i = 0; i < 4; i++) sendSample(16'(16'hC000 + i));
    dout_ready = 1'b1;
    n = 0;
    while ((xferCyc.size() < 3) && (n < 20)) begin
      tick();
      n++;
    end
    dout_ready = 1'b0;
    check("t5_pre_xfers", 16'(xferCyc.size()), 16'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t5_valid", 16'(dout_valid), 16'd0);
    check("t5_frame_count", frame_count, 16'd0);
    check("t5_busy", 16'(busy), 16'd0);
    tick();
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) sendSample(16'(16'hD000 + i));
    waitIdle(50);

    // 6: sequence number wrap from FFFF to 0000
    force dut.seq = 16'hFFFF;
    preloadVal = 16'hFFFF;
    preloadReq = 1'b1;
    tick();
    release dut.seq;
    preloadReq = 1'b0;
    for (int i = 0; i < 8; i++) sendSample(16'(16'hE000 + i));
    waitIdle(50);
    check("t6_frame_count", frame_count, 16'd1);

    // 7: randomized traffic with backpressure and occasional clears
    for (int i = 0; i < 1500; i++) begin
      enable        = ($urandom_range(0, 9) != 0);
      sample_valid  = $urandom_range(0, 1) == 1;
      sample_in     = 16'($urandom);
      dout_ready    = ($urandom_range(0, 9) < 7);
      overrun_clear = ($urandom_range(0, 29) == 0);
      tick();
    end
    enable = 1'b0;
    overrun_clear = 1'b0;
    dout_ready = 1'b1;
    n = 0;
    while ((mPos != 0) && (n < 200)) begin
      sample_valid = 1'b1;
      sample_in    = 16'($urandom);
      tick();
      n++;
    end
    sample_valid = 1'b0;
    waitIdle(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
